// File: rtl/param_loader_pkg.sv
// Shared types and constants for the parameter loader.
package param_loader_pkg;

  // Fixed-point parameter word width.
  localparam int N = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    FLUSH = 2'd2
  } state_t;

  // Sign-extend one parameter word to the double-width bus.
  function automatic logic [2*N-1:0] sext(input logic [N-1:0] x);
    return {{N{x[N-1]}}, x};
  endfunction

endpackage

// File: rtl/param_loader_bus_drv.sv
// Registered tristate driver: data and output enable are captured together,
// so the bus never glitches on turn-around.
module bus_drv
  import param_loader_pkg::*;
#(
  parameter int w = 2*N
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic [w-1:0] d,
  inout  wire  [w-1:0] bus
);

  logic [w-1:0] q;
  logic         oe;

  // Capture the word and its enable on the same edge.
  always_ff @(posedge clk) begin
    if (!rst) begin
      q  <= '0;
      oe <= 1'b0;
    end else begin
      oe <= en;
      if (en) q <= d;
    end
  end

  assign bus = oe ? q : 'z;

endmodule

// File: rtl/param_loader.sv
// Streams weights and biases into the per-node parameter shift registers,
// walking hidden layer 1, hidden layer 2 and the output layer, node nd-1 down to 0.
module param_loader
  import param_loader_pkg::*;
#(
  parameter  int sx  = 99,
  parameter  int sl1 = 99,
  parameter  int sl2 = 99,
  parameter  int sl  = 99,
  localparam int nd  = sl1 + sl2 + sl,
  localparam int n   = N
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [n-1:0]    in_data,
  input  logic            in_valid,
  output logic            in_ready,
  output logic [nd-1:0]   we,
  inout  wire  [2*n-1:0]  bus,
  output logic            busy,
  output logic            done
);

  localparam int MAX12  = (sx > sl1) ? sx : sl1;
  localparam int MAXFAN = (MAX12 > sl2) ? MAX12 : sl2;
  localparam int KW     = (nd > 1) ? $clog2(nd) : 1;
  localparam int JW     = (MAXFAN > 0) ? $clog2(MAXFAN + 1) : 1;

  // Layer boundaries in node-index space; node nd-1 is the first node of layer 1.
  localparam logic [KW-1:0] K_FIRST = KW'(nd - 1);
  localparam logic [KW-1:0] L1_LO   = KW'(nd - sl1);
  localparam logic [KW-1:0] L2_LO   = KW'(sl);

  // Index of the last word (the bias) of node kk, i.e. its fan-in.
  function automatic logic [JW-1:0] fan_in(input logic [KW-1:0] kk);
    if (kk >= L1_LO)      return JW'(sx);
    else if (kk >= L2_LO) return JW'(sl1);
    else                  return JW'(sl2);
  endfunction

  state_t          state, state_d;
  logic [KW-1:0]   k;
  logic [JW-1:0]   j;
  logic            accept;
  logic            node_end;
  logic            last_word;
  logic [nd-1:0]   one_hot;

  assign accept    = in_valid & in_ready;
  assign node_end  = (j == fan_in(k));
  assign last_word = node_end && (k == '0);

  // State register.
  always_ff @(posedge clk) begin
    if (!rst) state <= IDLE;
    else      state <= state_d;
  end

  // Next-state logic; start is only looked at in IDLE.
  always_comb begin
    state_d = state;
    case (state)
      IDLE:    if (start) state_d = LOAD;
      LOAD:    if (accept && last_word) state_d = FLUSH;
      FLUSH:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Handshake and status outputs decoded from the state.
  always_comb begin
    in_ready = (state == LOAD);
    busy     = (state != IDLE);
    done     = (state == FLUSH);
  end

  // Node and word counters advance only on accepted words; k wraps after the last node.
  always_ff @(posedge clk) begin
    if (!rst) begin
      k <= K_FIRST;
      j <= '0;
    end else if (accept) begin
      if (node_end) begin
        j <= '0;
        k <= (k == '0) ? K_FIRST : k - KW'(1);
      end else begin
        j <= j + JW'(1);
      end
    end
  end

  // One-hot select of the current node.
  always_comb begin
    one_hot = {{(nd-1){1'b0}}, 1'b1} << k;
  end

  // Write enable lags the accept by one cycle, aligned with the bus driver.
  always_ff @(posedge clk) begin
    if (!rst)        we <= '0;
    else if (accept) we <= one_hot;
    else             we <= '0;
  end

  bus_drv #(
    .w (2*n)
  ) u_bus_drv (
    .clk (clk),
    .rst (rst),
    .en  (accept),
    .d   (sext(in_data)),
    .bus (bus)
  );

endmodule

// File: tb/tb_param_loader.sv
// Directed bench for param_loader with sx=2, sl1=2, sl2=2, sl=1 (nd=5, 15 words).
module tb_param_loader;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [15:0] in_data;
  logic        in_valid;
  logic        in_ready;
  logic [4:0]  we;
  wire  [31:0] bus;
  logic        busy;
  logic        done;

  int checks = 0;
  int errors = 0;

  logic [15:0] words [15];
  logic [31:0] z32;

  always #5 clk = ~clk;

  param_loader #(
    .sx  (2),
    .sl1 (2),
    .sl2 (2),
    .sl  (1)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .in_data  (in_data),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .we       (we),
    .bus      (bus),
    .busy     (busy),
    .done     (done)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One full load. bubble: idle cycle before every odd word. poke: start
  // asserted mid-LOAD and during FLUSH. sv: in_valid high in the start cycle.
  task automatic stream(input bit bubble, input bit poke, input bit sv);
    int writes;
    int dones;
    logic [4:0] first;
    logic [4:0] exp_we;
    logic [31:0] exp_bus;
    writes = 0;
    dones  = 0;
    first  = 5'b10000;

    start = 1'b1; in_valid = sv; in_data = 16'hAAAA;
    tick();
    start = 1'b0; in_valid = 1'b0;
    check("start_we", 32'(we), 32'h0);
    check("start_busy", 32'(busy), 32'h1);

    for (int i = 0; i < 15; i++) begin
      if (bubble && (i % 2 == 1)) begin
        in_valid = 1'b0; in_data = 16'h5555;
        tick();
        check("bubble_we", 32'(we), 32'h0);
        check("bubble_bus", bus, z32);
        check("bubble_done", 32'(done), 32'h0);
        if (done) dones++;
      end
      check("in_ready_load", 32'(in_ready), 32'h1);
      in_valid = 1'b1;
      in_data  = words[i];
      start    = poke && (i == 5);
      tick();
      start = 1'b0; in_valid = 1'b0;
      exp_we  = first >> (i / 3);
      exp_bus = {{16{words[i][15]}}, words[i]};
      check("word_we", 32'(we), 32'(exp_we));
      check("word_bus", bus, exp_bus);
      check("word_done", 32'(done), (i == 14) ? 32'h1 : 32'h0);
      if (we != 5'b0) writes++;
      if (done) dones++;
    end

    check("flush_in_ready", 32'(in_ready), 32'h0);
    check("flush_busy", 32'(busy), 32'h1);
    start = poke;
    tick();
    start = 1'b0;
    check("idle_done", 32'(done), 32'h0);
    check("idle_busy", 32'(busy), 32'h0);
    check("idle_we", 32'(we), 32'h0);
    check("idle_bus", bus, z32);
    check("idle_in_ready", 32'(in_ready), 32'h0);
    if (we != 5'b0) writes++;
    tick();
    check("idle2_busy", 32'(busy), 32'h0);
    check("idle2_we", 32'(we), 32'h0);
    check("write_count", 32'(writes), 32'd15);
    check("done_count", 32'(dones), 32'd1);
  endtask

  initial begin
    z32      = 'z;
    rst      = 1'b0;
    start    = 1'b0;
    in_valid = 1'b0;
    in_data  = 16'h0;
    repeat (3) tick();
    rst = 1'b1;
    tick();
    check("rst_we", 32'(we), 32'h0);
    check("rst_bus", bus, z32);
    check("rst_in_ready", 32'(in_ready), 32'h0);
    check("rst_busy", 32'(busy), 32'h0);
    check("rst_done", 32'(done), 32'h0);

    // Abandon a load after four accepts.
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1; in_data = 16'(i + 16'h0040);
      tick();
    end
    check("mid_we", 32'(we), 32'h08);
    rst = 1'b0; in_valid = 1'b1; in_data = 16'h1234;
    tick();
    in_valid = 1'b0;
    check("abort_we", 32'(we), 32'h0);
    check("abort_bus", bus, z32);
    check("abort_busy", 32'(busy), 32'h0);
    check("abort_in_ready", 32'(in_ready), 32'h0);
    rst = 1'b1;
    tick();

    // Fresh load after the abort: must restart at node 4, word 0.
    for (int i = 0; i < 15; i++) words[i] = 16'(i + 1);
    stream(1'b0, 1'b0, 1'b0);

    // Sign extension at both extremes; start+valid together accepts nothing.
    for (int i = 0; i < 15; i++) words[i] = 16'(16'h0100 + i);
    words[0] = 16'h8001;
    words[1] = 16'h7FFF;
    words[7] = 16'hFFFF;
    stream(1'b0, 1'b0, 1'b1);

    // Bubbles between words.
    for (int i = 0; i < 15; i++) words[i] = 16'(16'hC000 + 16'(i * 3));
    stream(1'b1, 1'b0, 1'b0);

    // start poked mid-LOAD and during FLUSH.
    for (int i = 0; i < 15; i++) words[i] = 16'(16'h2000 + i);
    stream(1'b0, 1'b1, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
